if_fetch_unit: RTL and testbench

Instruction-fetch stage of the LEGv8 datapath. Holds the fetch PC, issues word requests to instruction memory over a valid/ready channel, and buffers returned instructions with their PC. It presents them to decode, where the sign-extend and control logic consume the 32-bit instruction. It accepts a branch redirect (target = PC + extended offset, computed downstream), flushes buffered and in-flight fetches, and restarts at the target.

---
 rtl/legv8_pkg.sv | 19 +
 rtl/sync_fifo.sv | 47 ++++
 rtl/if_fetch_unit.sv | 85 ++++++++
 tb/tb_if_fetch_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 constants used by fetch and decode.
package legv8_pkg;
  localparam int INST_W     = 32;
  localparam int ADDR_W     = 64;
  localparam int INST_BYTES = 4;

  // Opcode fields consumed by decode.
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a synchronous flush; head is the oldest entry.
module sync_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero until first write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/if_fetch_unit.sv
// LEGv8 instruction fetch: credit-limited requests to imem, in-order response
// buffering with PC tags, and branch redirect with flush of stale fetches.
module if_fetch_unit
  import legv8_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);
  // Handshakes: a transfer happens in any cycle where valid && ready are both
  // high at the rising edge; valid never depends on ready of the same channel
  // and the payload is held while valid is high and ready is low.
  // imem_rsp has no ready: the credit rule guarantees a free buffer slot.
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = CW + 2;

  logic [ADDR_W-1:0]        pc_fetch, rsp_pc, target;
  logic [CW-1:0]            outstanding, buf_count;
  logic [DW-1:0]            drop_cnt;
  logic [CW:0]              committed;
  logic                     credit, req_fire, pop, rsp_live, rsp_drop, buf_empty;
  logic [INST_W+ADDR_W-1:0] buf_head;

  assign target    = word_align(redirect_target);
  assign pop       = inst_valid && inst_ready;
  // A pop in this cycle frees its slot, which keeps 1 inst/cycle streaming.
  assign committed = {1'b0, outstanding} + {1'b0, buf_count} - (CW+1)'(pop);
  assign credit    = committed < (CW+1)'(DEPTH);

  assign imem_req_valid = credit && !redirect_valid;
  assign imem_req_addr  = pc_fetch;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_live       = imem_rsp_valid && (drop_cnt == '0);

  // outstanding counts live requests only; stale ones move to drop_cnt so the
  // target can be fetched the cycle after a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_fetch    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      pc_fetch    <= target;
      rsp_pc      <= target;
      outstanding <= '0;
      drop_cnt    <= drop_cnt + DW'(outstanding) - DW'(imem_rsp_valid);
    end else begin
      if (req_fire) pc_fetch <= pc_fetch + ADDR_W'(INST_BYTES);
      if (rsp_live) rsp_pc <= rsp_pc + ADDR_W'(INST_BYTES);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_live);
      if (rsp_drop) drop_cnt <= drop_cnt - DW'(1);
    end
  end

  sync_fifo #(.W(INST_W + ADDR_W), .DEPTH(DEPTH)) u_inst_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (rsp_live && !redirect_valid),
    .push_data ({imem_rsp_data, rsp_pc}),
    .pop       (pop),
    .head      (buf_head),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  assign inst_valid = !buf_empty;
  assign inst       = buf_head[INST_W+ADDR_W-1:ADDR_W];
  assign inst_pc    = buf_head[ADDR_W-1:0];
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory model with in-order variable latency and a
// queue of PCs expected at decode since the last redirect.
module tb_if_fetch_unit;
  localparam logic [63:0] RESET_PC = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        inst_valid, inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t    mem_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] exp_req;
  int compared = 0, mismatched = 0;
  int cyc = 0, last_due = 0;
  int ready_mode = 0, lat_min = 1, lat_max = 1;
  int n_fires = 0, n_pops = 0, first_req_cyc = -1, first_pop_cyc = -1;
  logic        gap_chk = 1'b0;
  logic        has_pop_after = 1'b0, has_fire_after = 1'b0;
  logic [63:0] first_pop_after, first_fire_after, last_pop_pc, held_pc;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[33:2] * 32'h9E37_79B9) ^ a[63:32];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, update the model.
  task automatic step(input logic rdy, input logic redir, input logic [63:0] tgt);
    logic rsp_now;
    int   lat, due;
    @(negedge clk);
    cyc++;
    case (ready_mode)
      0:       imem_req_ready = 1'b1;
      1:       imem_req_ready = 1'($urandom_range(0, 1));
      default: imem_req_ready = 1'b0;
    endcase
    rsp_now = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid  = rsp_now;
    imem_rsp_data   = rsp_now ? mem_word(mem_q[0].addr) : $urandom;
    inst_ready      = rdy;
    redirect_valid  = redir;
    redirect_target = tgt;
    #1;
    if (gap_chk) begin
      check("inst_valid_after_redirect", 64'(inst_valid), 64'd0);
      gap_chk = 1'b0;
    end
    if (inst_valid && inst_ready) begin
      if (exp_q.size() == 0) check("pop_without_request", 64'(inst_pc), 64'hDEAD_BEEF_DEAD_BEEF);
      else check("inst_pc", inst_pc, exp_q.pop_front());
      check("inst_word", 64'(inst), 64'(mem_word(inst_pc)));
      n_pops++;
      last_pop_pc = inst_pc;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      if (!has_pop_after) begin has_pop_after = 1'b1; first_pop_after = inst_pc; end
    end
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, exp_req);
      lat = $urandom_range(lat_min, lat_max);
      due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = due;
      mem_q.push_back('{addr: imem_req_addr, due: due});
      exp_q.push_back(exp_req);
      exp_req += 64'd4;
      n_fires++;
      if (first_req_cyc < 0) first_req_cyc = cyc;
      if (!has_fire_after) begin has_fire_after = 1'b1; first_fire_after = imem_req_addr; end
    end
    if (redir) begin
      check("req_during_redirect", 64'(imem_req_valid), 64'd0);
      exp_req = {tgt[63:2], 2'b00};
      exp_q.delete();
      gap_chk = 1'b1;
      has_pop_after = 1'b0;
      has_fire_after = 1'b0;
    end
    check("credit_limit", 64'(exp_q.size() <= DEPTH), 64'd1);
    if (rsp_now) void'(mem_q.pop_front());
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_target = '0; inst_ready = 1'b0;
    #1;
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_inst_pc", inst_pc, 64'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    mem_q.delete(); exp_q.delete();
    last_due = 0; exp_req = RESET_PC; gap_chk = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset and streaming at 1-cycle latency, wrapping past 2^64.
    apply_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0);
    check("stream_fires", 64'(n_fires), 64'd12);
    check("stream_pops", 64'(n_pops), 64'd10);
    check("first_inst_latency", 64'(first_pop_cyc - first_req_cyc), 64'd2);

    // Decode stalls: buffer fills, head held, requests stop.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, '0);
      if (i == 0) held_pc = exp_q[0];
      check("stall_valid", 64'(inst_valid), 64'd1);
      check("stall_head_pc", inst_pc, held_pc);
    end
    check("stall_req_valid", 64'(imem_req_valid), 64'd0);
    check("stall_buffered", 64'(exp_q.size()), 64'(DEPTH));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);

    // Redirect with two requests in flight at latency 3.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && mem_q.size() < 2; i++) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 64'h1000);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, '0);
    check("redir_first_fire", first_fire_after, 64'h1000);
    check("redir_first_pop", first_pop_after, 64'h1000);

    // Redirect coinciding with the decode handshake of the branch at 0x40.
    lat_min = 1; lat_max = 1;
    step(1'b1, 1'b1, 64'h40);
    for (int i = 0; i < 10 && !inst_valid; i++) step(1'b0, 1'b0, '0);
    check("cbz_visible", 64'(inst_valid), 64'd1);
    begin
      int pops_before;
      pops_before = n_pops;
      step(1'b1, 1'b1, 64'h2003);
      check("cbz_popped_once", 64'(n_pops), 64'(pops_before + 1));
      check("cbz_pc", last_pop_pc, 64'h40);
    end

    // Memory not ready: address and valid held, pc_fetch frozen.
    ready_mode = 2;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, '0);
      check("hold_valid", 64'(imem_req_valid), 64'd1);
      check("hold_addr", imem_req_addr, 64'h2000);
    end
    ready_mode = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);
    check("hold_first_fire", first_fire_after, 64'h2000);

    // Back-to-back redirects: the later target wins.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 64'h3000);
    step(1'b1, 1'b1, 64'h5001);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, '0);
    check("b2b_has_pop", 64'(has_pop_after), 64'd1);
    check("b2b_first_pop", first_pop_after, 64'h5000);

    // Random traffic against the model.
    ready_mode = 1; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 800; i++) begin
      logic        rdy, redir;
      logic [63:0] tgt;
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 24) == 0);
      tgt   = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom_range(0, 15))}
                                          : {$urandom, $urandom};
      step(rdy, redir, tgt);
    end

    // Reset mid-operation discards all state.
    apply_reset();
    ready_mode = 0; lat_min = 1; lat_max = 1;
    has_pop_after = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);
    check("post_reset_first_pop", first_pop_after, RESET_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
